// File: rtl/stepdown_drv_pkg.sv
// rtl/stepdown_drv_pkg.sv - phase-state encoding and dead-time load helper
package stepdown_drv_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_LS_ON = 3'd1,
        ST_DT_LH = 3'd2,
        ST_HS_ON = 3'd3,
        ST_DT_HL = 3'd4
    } ph_state_e;

    // A zero dead-time still has to produce one both-off cycle.
    function automatic logic [31:0] dt_load(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/stepdown_dt_phase.sv
// rtl/stepdown_dt_phase.sv - one phase: switching FSM, dead-time counter, sticky fault
module stepdown_dt_phase
    import stepdown_drv_pkg::*;
#(
    parameter int DTW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           pwm,
    input  logic           fault,
    input  logic           clr,
    input  logic [DTW-1:0] dt_lh,
    input  logic [DTW-1:0] dt_hl,
    output logic           hs,
    output logic           ls,
    output logic           flt
);

    ph_state_e      state_q;
    ph_state_e      state_d;
    logic [DTW-1:0] cnt_q;
    logic [DTW-1:0] cnt_d;
    logic [DTW-1:0] lh_load;
    logic [DTW-1:0] hl_load;
    logic           kill;

    assign lh_load = DTW'(dt_load(32'(dt_lh)));
    assign hl_load = DTW'(dt_load(32'(dt_hl)));

    // The registered flag keeps the phase down until it is explicitly cleared.
    assign kill = rst | ~en | fault | flt;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (kill) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (pwm) begin
                        state_d = ST_DT_LH;
                        cnt_d   = lh_load;
                    end else begin
                        state_d = ST_DT_HL;
                        cnt_d   = hl_load;
                    end
                end
                ST_LS_ON: begin
                    if (pwm) begin
                        state_d = ST_DT_LH;
                        cnt_d   = lh_load;
                    end
                end
                ST_HS_ON: begin
                    if (!pwm) begin
                        state_d = ST_DT_HL;
                        cnt_d   = hl_load;
                    end
                end
                // Both switches are already off, so reversing mid-count is safe.
                ST_DT_LH: begin
                    if (!pwm) begin
                        state_d = ST_LS_ON;
                    end else if (cnt_q == DTW'(1)) begin
                        state_d = ST_HS_ON;
                    end else begin
                        cnt_d = cnt_q - DTW'(1);
                    end
                end
                ST_DT_HL: begin
                    if (pwm) begin
                        state_d = ST_HS_ON;
                    end else if (cnt_q == DTW'(1)) begin
                        state_d = ST_LS_ON;
                    end else begin
                        cnt_d = cnt_q - DTW'(1);
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            hs      <= 1'b0;
            ls      <= 1'b0;
            flt     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hs      <= (state_q == ST_HS_ON);
            ls      <= (state_q == ST_LS_ON);
            if (fault) begin
                flt <= 1'b1;
            end else if (clr) begin
                flt <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stepdown_driver_deadtime.sv
// rtl/stepdown_driver_deadtime.sv - multi-phase complementary gate driver with dead-time
module stepdown_driver_deadtime
    import stepdown_drv_pkg::*;
#(
    parameter int NPH    = 1,
    parameter int DTW    = 6,
    parameter int LS_INV = 0
) (
    input  logic           CELCLK,
    input  logic           CELRST,
    input  logic           CELV,
    input  logic           CELG,
    input  logic           SUB,
    input  logic           en_i,
    input  logic [NPH-1:0] pwm_i,
    input  logic [NPH-1:0] fault_i,
    input  logic           clr_i,
    input  logic [DTW-1:0] dt_lh_i,
    input  logic [DTW-1:0] dt_hl_i,
    output logic [NPH-1:0] hs_o,
    output logic [NPH-1:0] ls_o,
    output logic [NPH-1:0] flt_o
);

    localparam logic [NPH-1:0] LS_MASK = (LS_INV != 0) ? {NPH{1'b1}} : {NPH{1'b0}};

    logic [NPH-1:0] ls_on;

    // Supply pins exist for the functional view only.
    wire unused_supply = ^{CELV, CELG, SUB};

    for (genvar p = 0; p < NPH; p++) begin : g_phase
        stepdown_dt_phase #(
            .DTW(DTW)
        ) u_phase (
            .clk  (CELCLK),
            .rst  (CELRST),
            .en   (en_i),
            .pwm  (pwm_i[p]),
            .fault(fault_i[p]),
            .clr  (clr_i),
            .dt_lh(dt_lh_i),
            .dt_hl(dt_hl_i),
            .hs   (hs_o[p]),
            .ls   (ls_on[p]),
            .flt  (flt_o[p])
        );
    end

    // Polarity flip for an odd-length downstream inverter chain.
    assign ls_o = ls_on ^ LS_MASK;

endmodule
